// File: rtl/rv_sim_ctrl.sv
// -----------------------------------------------------------------------------
// rv_sim_ctrl
//   Simulation controller for the multi-hart pipelined RISC-V cores. It holds
//   the cores in reset for RST_CYCLES cycles, lets them run, and decides the
//   end of the test. While running it counts RUN cycles and retired
//   instructions per hart. It watches every hart's data stores for writes to
//   the tohost address, and it stops the run through a global watchdog and a
//   no-progress (stall) watchdog. The block is synthesisable, so the same
//   harness runs on FPGA.
//
// Ports
//   clk         core clock, all logic on rising edge
//   rst         synchronous active-high reset
//   core_rst    reset to the cores, high in HOLD and DONE
//   retire      bit h: hart h retired one instruction this cycle
//   st_valid    bit h: hart h issues a data store this cycle
//   st_addr     store address, hart h at [32h+31:32h]
//   st_data     store data, same packing
//   done        test finished (pass, fail or timeout), sticky until rst
//   pass        all harts reported pass (valid when done)
//   timeout     done was caused by a watchdog
//   fail_hart   index of the failing hart
//   fail_code   st_data>>1 of the failing store
//   cycle_cnt   cycles spent in RUN (saturating)
//   retire_cnt  retired instructions per hart, CNT_W each (saturating)
// -----------------------------------------------------------------------------
module rv_sim_ctrl #(
   parameter int          NUM_HARTS   = 1,
   parameter int          CNT_W       = 32,
   parameter int          RST_CYCLES  = 4,
   parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000,
   parameter int          TIMEOUT     = 100000,
   parameter int          STALL_LIMIT = 1000
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       core_rst,
   input  logic [NUM_HARTS-1:0]       retire,
   input  logic [NUM_HARTS-1:0]       st_valid,
   input  logic [NUM_HARTS*32-1:0]    st_addr,
   input  logic [NUM_HARTS*32-1:0]    st_data,
   output logic                       done,
   output logic                       pass,
   output logic                       timeout,
   output logic [2:0]                 fail_hart,
   output logic [31:0]                fail_code,
   output logic [CNT_W-1:0]           cycle_cnt,
   output logic [NUM_HARTS*CNT_W-1:0] retire_cnt
);

   localparam int                HOLD_W     = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
   localparam logic [63:0]       TIMEOUT_L  = 64'(TIMEOUT);
   localparam logic [31:0]       STALL_LAST = 32'(STALL_LIMIT - 1);

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [HOLD_W-1:0]     hold_cnt;
   logic [31:0]           stall_cnt;
   logic [NUM_HARTS-1:0]  pass_seen;

   // tohost decode of the current cycle's stores
   logic [NUM_HARTS-1:0]  pass_now;
   logic                  fail_any;
   logic [2:0]            fail_idx;
   logic [31:0]           fail_val;
   logic                  all_pass;
   logic                  tmo_hit;
   logic                  stall_hit;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   // Scan from the highest hart down so the lowest failing index is the one
   // left standing when several harts fail in the same cycle.
   always_comb begin
      pass_now = '0;
      fail_any = 1'b0;
      fail_idx = 3'd0;
      fail_val = 32'd0;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         if (st_valid[h] && (st_addr[32*h +: 32] == TOHOST_ADDR)) begin
            if (st_data[32*h +: 32] == 32'd1) begin
               pass_now[h] = 1'b1;
            end else if (st_data[32*h]) begin
               fail_any = 1'b1;
               fail_idx = 3'(h);
               fail_val = st_data[32*h +: 32] >> 1;
            end
         end
      end
   end

   // A pass arriving this cycle counts toward the all-pass condition.
   assign all_pass  = &(pass_seen | pass_now);
   // Both watchdogs look at the counter values before this cycle's update.
   assign tmo_hit   = (TIMEOUT != 0) && (64'(cycle_cnt) == TIMEOUT_L);
   assign stall_hit = (STALL_LIMIT != 0) && (retire == '0) && (stall_cnt == STALL_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_HOLD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      core_rst  = 1'b1;
      done      = 1'b0;
      case (state)
         S_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            core_rst = 1'b0;
            if (fail_any || all_pass || tmo_hit || stall_hit) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            state_nxt = S_HOLD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt   <= '0;
         stall_cnt  <= '0;
         pass_seen  <= '0;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         pass       <= 1'b0;
         timeout    <= 1'b0;
         fail_hart  <= 3'd0;
         fail_code  <= 32'd0;
      end else begin
         case (state)
            S_HOLD: begin
               if (hold_cnt != HOLD_LAST) begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            S_RUN: begin
               cycle_cnt <= sat_inc(cycle_cnt);
               for (int h = 0; h < NUM_HARTS; h++) begin
                  if (retire[h]) begin
                     retire_cnt[h*CNT_W +: CNT_W] <= sat_inc(retire_cnt[h*CNT_W +: CNT_W]);
                  end
               end
               stall_cnt <= (|retire) ? 32'd0 : sat_inc32(stall_cnt);
               pass_seen <= pass_seen | pass_now;
               // Outcome priority: failure, then all-pass, then watchdog.
               if (fail_any) begin
                  pass      <= 1'b0;
                  timeout   <= 1'b0;
                  fail_hart <= fail_idx;
                  fail_code <= fail_val;
               end else if (all_pass) begin
                  pass <= 1'b1;
               end else if (tmo_hit || stall_hit) begin
                  timeout   <= 1'b1;
                  pass      <= 1'b0;
                  fail_hart <= 3'd0;
                  fail_code <= 32'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_sim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv_sim_ctrl
//   Directed bench for rv_sim_ctrl using three instances:
//     u1: 1 hart, default watchdogs (reset sequencing, pass, rst mid-RUN/DONE)
//     u2: 2 harts, STALL_LIMIT=10, TIMEOUT=30 (fail priority, watchdogs)
//     u3: 1 hart, CNT_W=4, watchdogs disabled (counter saturation)
// -----------------------------------------------------------------------------
module tb_rv_sim_ctrl;

   localparam logic [31:0] TH = 32'h8000_1000;

   logic clk;
   int   n_tests;
   int   n_fail;

   // u1
   logic        r1_rst, r1_ret, r1_sv;
   logic [31:0] r1_sa, r1_sd;
   logic        o1_crst, o1_done, o1_pass, o1_tmo;
   logic [2:0]  o1_fh;
   logic [31:0] o1_fc, o1_cyc, o1_ret;

   // u2
   logic        r2_rst;
   logic [1:0]  r2_ret, r2_sv;
   logic [63:0] r2_sa, r2_sd;
   logic        o2_crst, o2_done, o2_pass, o2_tmo;
   logic [2:0]  o2_fh;
   logic [31:0] o2_fc, o2_cyc;
   logic [63:0] o2_ret;

   // u3
   logic        r3_rst, r3_ret, r3_sv;
   logic [31:0] r3_sa, r3_sd;
   logic        o3_crst, o3_done, o3_pass, o3_tmo;
   logic [2:0]  o3_fh;
   logic [31:0] o3_fc;
   logic [3:0]  o3_cyc, o3_ret;

   rv_sim_ctrl #(.NUM_HARTS(1), .CNT_W(32), .RST_CYCLES(4), .TOHOST_ADDR(TH),
                 .TIMEOUT(100000), .STALL_LIMIT(1000)) u1 (
      .clk(clk), .rst(r1_rst), .core_rst(o1_crst), .retire(r1_ret),
      .st_valid(r1_sv), .st_addr(r1_sa), .st_data(r1_sd), .done(o1_done),
      .pass(o1_pass), .timeout(o1_tmo), .fail_hart(o1_fh), .fail_code(o1_fc),
      .cycle_cnt(o1_cyc), .retire_cnt(o1_ret));

   rv_sim_ctrl #(.NUM_HARTS(2), .CNT_W(32), .RST_CYCLES(4), .TOHOST_ADDR(TH),
                 .TIMEOUT(30), .STALL_LIMIT(10)) u2 (
      .clk(clk), .rst(r2_rst), .core_rst(o2_crst), .retire(r2_ret),
      .st_valid(r2_sv), .st_addr(r2_sa), .st_data(r2_sd), .done(o2_done),
      .pass(o2_pass), .timeout(o2_tmo), .fail_hart(o2_fh), .fail_code(o2_fc),
      .cycle_cnt(o2_cyc), .retire_cnt(o2_ret));

   rv_sim_ctrl #(.NUM_HARTS(1), .CNT_W(4), .RST_CYCLES(4), .TOHOST_ADDR(TH),
                 .TIMEOUT(0), .STALL_LIMIT(0)) u3 (
      .clk(clk), .rst(r3_rst), .core_rst(o3_crst), .retire(r3_ret),
      .st_valid(r3_sv), .st_addr(r3_sa), .st_data(r3_sd), .done(o3_done),
      .pass(o3_pass), .timeout(o3_tmo), .fail_hart(o3_fh), .fail_code(o3_fc),
      .cycle_cnt(o3_cyc), .retire_cnt(o3_ret));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One rst cycle on u2, then the 4-cycle hold; returns with u2 in RUN.
   task automatic r2_restart();
      r2_rst = 1'b1;
      r2_ret = '0;
      r2_sv  = '0;
      r2_sa  = '0;
      r2_sd  = '0;
      step();
      r2_rst = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      r1_rst = 1'b1; r1_ret = 1'b0; r1_sv = 1'b0; r1_sa = '0; r1_sd = '0;
      r2_rst = 1'b1; r2_ret = '0;   r2_sv = '0;   r2_sa = '0; r2_sd = '0;
      r3_rst = 1'b1; r3_ret = 1'b0; r3_sv = 1'b0; r3_sa = '0; r3_sd = '0;

      // ---------------- reset state ----------------
      repeat (3) step();
      chk("rst_core_rst", 64'(o1_crst), 64'd1);
      chk("rst_done",     64'(o1_done), 64'd0);
      chk("rst_pass",     64'(o1_pass), 64'd0);
      chk("rst_timeout",  64'(o1_tmo),  64'd0);
      chk("rst_fail_hart",64'(o1_fh),   64'd0);
      chk("rst_fail_code",64'(o1_fc),   64'd0);
      chk("rst_cycle",    64'(o1_cyc),  64'd0);
      chk("rst_retire",   64'(o1_ret),  64'd0);
      chk("rst_u2_core",  64'(o2_crst), 64'd1);
      chk("rst_u2_ret",   o2_ret,       64'd0);

      // ---------------- 1) hold sequencing ----------------
      r1_rst = 1'b0;
      repeat (3) step();
      chk("hold_3_core_rst", 64'(o1_crst), 64'd1);
      step();
      chk("hold_4_core_rst", 64'(o1_crst), 64'd0);
      chk("hold_4_cycle",    64'(o1_cyc),  64'd0);

      // ---------------- 2) single-hart pass ----------------
      // First cycle also carries a store of 1 to a non-tohost address.
      r1_ret = 1'b1;
      r1_sv = 1'b1; r1_sa = TH + 32'd4; r1_sd = 32'd1;
      step();
      r1_sv = 1'b0;
      repeat (19) step();
      chk("run20_done",   64'(o1_done), 64'd0);
      chk("run20_retire", 64'(o1_ret),  64'd20);
      chk("run20_cycle",  64'(o1_cyc),  64'd20);
      r1_ret = 1'b0;
      r1_sv = 1'b1; r1_sa = TH; r1_sd = 32'd1;
      step();
      r1_sv = 1'b0;
      chk("pass_done",    64'(o1_done), 64'd1);
      chk("pass_pass",    64'(o1_pass), 64'd1);
      chk("pass_timeout", 64'(o1_tmo),  64'd0);
      chk("pass_retire",  64'(o1_ret),  64'd20);
      chk("pass_core_rst",64'(o1_crst), 64'd1);
      r1_ret = 1'b1;
      repeat (3) step();
      chk("frozen_cycle", 64'(o1_cyc),  64'd21);
      chk("frozen_retire",64'(o1_ret),  64'd20);
      chk("frozen_done",  64'(o1_done), 64'd1);

      // ---------------- 6) rst in DONE and mid-RUN ----------------
      r1_rst = 1'b1;
      step();
      chk("rstdone_done",  64'(o1_done), 64'd0);
      chk("rstdone_pass",  64'(o1_pass), 64'd0);
      chk("rstdone_core",  64'(o1_crst), 64'd1);
      chk("rstdone_cycle", 64'(o1_cyc),  64'd0);
      chk("rstdone_retire",64'(o1_ret),  64'd0);
      r1_rst = 1'b0;
      repeat (4) step();
      chk("rerun_core_rst",64'(o1_crst), 64'd0);
      repeat (5) step();
      chk("rerun_retire5", 64'(o1_ret),  64'd5);
      r1_rst = 1'b1;
      step();
      chk("rstrun_core",   64'(o1_crst), 64'd1);
      chk("rstrun_cycle",  64'(o1_cyc),  64'd0);
      chk("rstrun_retire", 64'(o1_ret),  64'd0);
      // retire stays high through HOLD and must be ignored there
      r1_rst = 1'b0;
      repeat (3) step();
      chk("hold_ignore_core", 64'(o1_crst), 64'd1);
      step();
      chk("hold_ignore_ret",  64'(o1_ret),  64'd0);
      chk("hold_ignore_core2",64'(o1_crst), 64'd0);
      repeat (3) step();
      r1_ret = 1'b0;
      r1_sv = 1'b1; r1_sa = TH; r1_sd = 32'd1;
      step();
      r1_sv = 1'b0;
      chk("rerun_done",   64'(o1_done), 64'd1);
      chk("rerun_pass",   64'(o1_pass), 64'd1);
      chk("rerun_retire", 64'(o1_ret),  64'd3);
      chk("rerun_cycle",  64'(o1_cyc),  64'd4);

      // ---------------- 3) two-hart failure cases ----------------
      r2_restart();
      chk("u2_core_rst", 64'(o2_crst), 64'd0);
      r2_ret = 2'b11;
      r2_sv = 2'b10; r2_sa = {TH, 32'd0}; r2_sd = {32'd1, 32'd0};
      step();
      r2_sv = 2'b00;
      step();
      chk("h1pass_done", 64'(o2_done), 64'd0);
      r2_sv = 2'b01; r2_sa = {32'd0, TH}; r2_sd = {32'd0, 32'h15};
      step();
      r2_sv = 2'b00;
      chk("h0fail_done",    64'(o2_done), 64'd1);
      chk("h0fail_pass",    64'(o2_pass), 64'd0);
      chk("h0fail_timeout", 64'(o2_tmo),  64'd0);
      chk("h0fail_hart",    64'(o2_fh),   64'd0);
      chk("h0fail_code",    64'(o2_fc),   64'h0A);
      chk("h0fail_retire",  o2_ret,       {32'd3, 32'd3});
      chk("h0fail_cycle",   64'(o2_cyc),  64'd3);

      r2_restart();
      r2_ret = 2'b11;
      r2_sv = 2'b11; r2_sa = {TH, TH}; r2_sd = {32'h9, 32'h7};
      step();
      r2_sv = 2'b00;
      chk("simfail_done", 64'(o2_done), 64'd1);
      chk("simfail_hart", 64'(o2_fh),   64'd0);
      chk("simfail_code", 64'(o2_fc),   64'h3);

      r2_restart();
      r2_ret = 2'b11;
      r2_sv = 2'b01; r2_sa = {32'd0, TH}; r2_sd = {32'd0, 32'd1};
      step();
      r2_sv = 2'b10; r2_sa = {TH, 32'd0}; r2_sd = {32'h21, 32'd0};
      step();
      r2_sv = 2'b00;
      chk("h1fail_done", 64'(o2_done), 64'd1);
      chk("h1fail_pass", 64'(o2_pass), 64'd0);
      chk("h1fail_hart", 64'(o2_fh),   64'd1);
      chk("h1fail_code", 64'(o2_fc),   64'h10);

      r2_restart();
      r2_ret = 2'b11;
      r2_sv = 2'b01; r2_sa = {32'd0, TH}; r2_sd = {32'd0, 32'd1};
      step();
      step();
      r2_sv = 2'b00;
      step();
      chk("halfpass_done", 64'(o2_done), 64'd0);
      r2_sv = 2'b10; r2_sa = {TH, 32'd0}; r2_sd = {32'd1, 32'd0};
      step();
      r2_sv = 2'b00;
      chk("allpass_done", 64'(o2_done), 64'd1);
      chk("allpass_pass", 64'(o2_pass), 64'd1);
      chk("allpass_tmo",  64'(o2_tmo),  64'd0);

      // ---------------- 4) stall watchdog ----------------
      r2_restart();
      r2_ret = 2'b01;
      repeat (5) step();
      r2_ret = 2'b00;
      r2_sv = 2'b01; r2_sa = {32'd0, TH}; r2_sd = {32'd0, 32'd2};
      step();
      r2_sv = 2'b00;
      repeat (8) step();
      chk("stall9_done", 64'(o2_done), 64'd0);
      step();
      chk("stall10_done",  64'(o2_done), 64'd1);
      chk("stall10_tmo",   64'(o2_tmo),  64'd1);
      chk("stall10_pass",  64'(o2_pass), 64'd0);
      chk("stall10_hart",  64'(o2_fh),   64'd0);
      chk("stall10_code",  64'(o2_fc),   64'd0);
      chk("stall10_cycle", 64'(o2_cyc),  64'd15);

      // fail in the same cycle the stall watchdog expires
      r2_restart();
      repeat (9) step();
      r2_sv = 2'b10; r2_sa = {TH, 32'd0}; r2_sd = {32'h3, 32'd0};
      step();
      r2_sv = 2'b00;
      chk("failvsstall_done", 64'(o2_done), 64'd1);
      chk("failvsstall_tmo",  64'(o2_tmo),  64'd0);
      chk("failvsstall_hart", 64'(o2_fh),   64'd1);
      chk("failvsstall_code", 64'(o2_fc),   64'h1);

      // global watchdog: retire alternates harts so the stall counter keeps clearing
      r2_restart();
      for (int i = 0; i < 30; i++) begin
         r2_ret = (i % 2 == 0) ? 2'b01 : 2'b10;
         step();
      end
      chk("glob30_done", 64'(o2_done), 64'd0);
      step();
      r2_ret = 2'b00;
      chk("glob31_done",  64'(o2_done), 64'd1);
      chk("glob31_tmo",   64'(o2_tmo),  64'd1);
      chk("glob31_cycle", 64'(o2_cyc),  64'd31);

      // ---------------- 5) saturation ----------------
      r3_rst = 1'b0;
      repeat (4) step();
      chk("u3_core_rst", 64'(o3_crst), 64'd0);
      r3_ret = 1'b1;
      repeat (14) step();
      chk("sat14_cycle",  64'(o3_cyc), 64'd14);
      chk("sat14_retire", 64'(o3_ret), 64'd14);
      repeat (6) step();
      chk("sat20_cycle",  64'(o3_cyc),  64'd15);
      chk("sat20_retire", 64'(o3_ret),  64'd15);
      chk("sat20_done",   64'(o3_done), 64'd0);
      r3_ret = 1'b0;
      repeat (5) step();
      chk("satidle_done",  64'(o3_done), 64'd0);
      chk("satidle_cycle", 64'(o3_cyc),  64'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
